// File: rtl/hazard_scoreboard_if.sv
// ID-stage interlock bus: decoded instruction fields flow from the pipeline
// into the scoreboard, and stall/status flow back.
interface hazard_scoreboard_if #(
  parameter int NREG   = 32,
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_dst;
  logic [1:0]        id_kind;
  logic              flush;
  logic              stall;
  logic [NREG-1:0]   busy_vec;
  logic              mul_busy;
  logic [PERF_W-1:0] stall_cycles;

  // Pipeline side: presents the ID instruction, consumes the interlock.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_dst, id_kind, flush,
    input  stall, busy_vec, mul_busy, stall_cycles
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_dst, id_kind, flush,
    output stall, busy_vec, mul_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. Each architectural register (except r0) has a
// countdown of cycles until its pending result can be forwarded; the
// multiplier has its own occupancy countdown. A combinational stall covers
// RAW, WAW and multiplier structural hazards, and stall cycles are counted
// in a saturating performance counter.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave idBus
);

  localparam logic [1:0]       KIND_LOAD = 2'd1;
  localparam logic [1:0]       KIND_MUL  = 2'd2;
  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [CNT_W-1:0]  cntReg [NREG];
  logic [CNT_W-1:0]  cntNext [NREG];
  logic [CNT_W-1:0]  mulCntReg;
  logic [CNT_W-1:0]  mulCntNext;
  logic [PERF_W-1:0] stallCyclesReg;
  logic [PERF_W-1:0] stallCyclesNext;

  logic [CNT_W-1:0]  idLat;
  logic              rsHazard;
  logic              rtHazard;
  logic              rawHazard;
  logic              wawHazard;
  logic              structHazard;
  logic              idLive;
  logic              stallInt;
  logic              issue;
  logic              setDst;

  // Result latency of the instruction currently in ID (reserved kind acts as ALU).
  always_comb begin
    idLat = '0;
    case (idBus.id_kind)
      KIND_LOAD: idLat = LOAD_CNT;
      KIND_MUL:  idLat = MUL_CNT;
      default:   idLat = '0;
    endcase
  end

  // Hazard terms; r0 is never a dependency because its entry is never set.
  always_comb begin
    rsHazard     = idBus.id_uses_rs && (idBus.id_rs != '0) &&
                   (cntReg[idBus.id_rs] != '0);
    rtHazard     = idBus.id_uses_rt && (idBus.id_rt != '0) &&
                   (cntReg[idBus.id_rt] != '0);
    rawHazard    = rsHazard || rtHazard;
    // A new writer must not finish before an older pending write to the same register.
    wawHazard    = idBus.id_wr_en && (idBus.id_dst != '0) &&
                   (cntReg[idBus.id_dst] > idLat);
    structHazard = (idBus.id_kind == KIND_MUL) && (mulCntReg != '0);
  end

  // A squashed instruction neither stalls nor issues.
  assign idLive   = idBus.id_valid && !idBus.flush;
  assign stallInt = idLive && (rawHazard || wawHazard || structHazard);
  assign issue    = idLive && !stallInt;
  assign setDst   = issue && idBus.id_wr_en && (idBus.id_dst != '0) && (idLat != '0);

  // Per-register countdown: a fresh issue overrides the decrement, otherwise count down to zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cntNext[r] = '0;
      if (r != 0) begin
        if (setDst && (idBus.id_dst == REG_AW'(r))) begin
          cntNext[r] = idLat;
        end else if (cntReg[r] != '0) begin
          cntNext[r] = cntReg[r] - CNT_ONE;
        end
      end
    end
  end

  // Multiplier occupancy is claimed by every issued MUL, even one with no destination.
  always_comb begin
    mulCntNext = '0;
    if (issue && (idBus.id_kind == KIND_MUL)) begin
      mulCntNext = MUL_CNT;
    end else if (mulCntReg != '0) begin
      mulCntNext = mulCntReg - CNT_ONE;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stallCyclesNext = stallCyclesReg;
    if (stallInt && (stallCyclesReg != '1)) begin
      stallCyclesNext = stallCyclesReg + PERF_ONE;
    end
  end

  // Scoreboard state registers; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cntReg[r] <= '0;
      end
      mulCntReg      <= '0;
      stallCyclesReg <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cntReg[r] <= cntNext[r];
      end
      mulCntReg      <= mulCntNext;
      stallCyclesReg <= stallCyclesNext;
    end
  end

  // Busy flags per register; r0 has no entry and always reads idle.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : gBusy
      if (gi == 0) begin : gZero
        assign idBus.busy_vec[gi] = 1'b0;
      end else begin : gReg
        assign idBus.busy_vec[gi] = (cntReg[gi] != '0);
      end
    end
  endgenerate

  assign idBus.stall        = stallInt;
  assign idBus.mul_busy     = (mulCntReg != '0);
  assign idBus.stall_cycles = stallCyclesReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step drives one ID-stage
// instruction, queues the expected interlock outputs and checks them.
module tb_hazard_scoreboard;

  localparam logic [1:0] ALU  = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(32), .REG_AW(5), .PERF_W(16)) bus ();
  // Second instance with a 4-bit stall counter so saturation is reached quickly.
  hazard_scoreboard_if #(.NREG(32), .REG_AW(5), .PERF_W(4)) satBus ();

  hazard_scoreboard #(
    .NREG(32), .REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .CNT_W(3), .PERF_W(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .idBus(bus)
  );

  hazard_scoreboard #(
    .NREG(32), .REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .CNT_W(3), .PERF_W(4)
  ) satDut (
    .clk  (clk),
    .rst  (rst),
    .idBus(satBus)
  );

  typedef struct {
    int          step;
    logic        stall;
    logic [31:0] busy;
    logic        mulBusy;
    logic [15:0] sc;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   stepNo     = 0;

  function automatic logic [31:0] rb(input int n);
    return 32'(1) << n;
  endfunction

  task automatic cmp(input string tag, input int step, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] dst, input logic [1:0] kind, input logic fl);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_wr_en   = wr;
    bus.id_dst     = dst;
    bus.id_kind    = kind;
    bus.flush      = fl;
  endtask

  task automatic pushExp(input logic st, input logic [31:0] bv, input logic mb,
                         input logic [15:0] sc);
    exp_t e;
    stepNo++;
    e.step    = stepNo;
    e.stall   = st;
    e.busy    = bv;
    e.mulBusy = mb;
    e.sc      = sc;
    expQ.push_back(e);
  endtask

  // Settle, pop the oldest expectation, compare, then advance to the next negedge.
  task automatic checkCycle();
    exp_t e;
    #1;
    e = expQ.pop_front();
    $display("step %0d: stall=%0b busy_vec=%08h mul_busy=%0b stall_cycles=%0d",
             e.step, bus.stall, bus.busy_vec, bus.mul_busy, bus.stall_cycles);
    cmp("stall",        e.step, 32'(bus.stall),        32'(e.stall));
    cmp("busy_vec",     e.step, bus.busy_vec,          e.busy);
    cmp("mul_busy",     e.step, 32'(bus.mul_busy),     32'(e.mulBusy));
    cmp("stall_cycles", e.step, 32'(bus.stall_cycles), 32'(e.sc));
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr,
                      input logic [4:0] dst, input logic [1:0] kind, input logic fl,
                      input logic st, input logic [31:0] bv, input logic mb,
                      input logic [15:0] sc);
    drive(v, rs, rt, urs, urt, wr, dst, kind, fl);
    pushExp(st, bv, mb, sc);
    checkCycle();
  endtask

  task automatic idle(input logic [31:0] bv, input logic mb, input logic [15:0] sc);
    step(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, bv, mb, sc);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, ALU, 0);
    satBus.id_valid   = 1'b0;
    satBus.id_rs      = 5'd0;
    satBus.id_rt      = 5'd0;
    satBus.id_uses_rs = 1'b0;
    satBus.id_uses_rt = 1'b0;
    satBus.id_wr_en   = 1'b0;
    satBus.id_dst     = 5'd0;
    satBus.id_kind    = ALU;
    satBus.flush      = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    idle(0, 0, 0);

    // Load-use: lw r2, then add r3,r2,r1 stalls one cycle.
    step(1, 0, 0, 0, 0, 1, 2, LOAD, 0,  0, 0,     0, 0);
    step(1, 2, 1, 1, 1, 1, 3, ALU,  0,  1, rb(2), 0, 0);
    step(1, 2, 1, 1, 1, 1, 3, ALU,  0,  0, 0,     0, 1);
    idle(0, 0, 1);

    // mul r4, then add r5,r4,r0 stalls three cycles.
    step(1, 1, 1, 1, 1, 1, 4, MUL,  0,  0, 0,     0, 1);
    step(1, 4, 0, 1, 1, 1, 5, ALU,  0,  1, rb(4), 1, 1);
    step(1, 4, 0, 1, 1, 1, 5, ALU,  0,  1, rb(4), 1, 2);
    step(1, 4, 0, 1, 1, 1, 5, ALU,  0,  1, rb(4), 1, 3);
    step(1, 4, 0, 1, 1, 1, 5, ALU,  0,  0, 0,     0, 4);

    // mul r4, then independent mul r6: structural stall.
    step(1, 1, 1, 1, 1, 1, 4, MUL,  0,  0, 0,     0, 4);
    step(1, 1, 1, 1, 1, 1, 6, MUL,  0,  1, rb(4), 1, 4);
    step(1, 1, 1, 1, 1, 1, 6, MUL,  0,  1, rb(4), 1, 5);
    step(1, 1, 1, 1, 1, 1, 6, MUL,  0,  1, rb(4), 1, 6);
    step(1, 1, 1, 1, 1, 1, 6, MUL,  0,  0, 0,     0, 7);
    idle(rb(6), 1, 7);
    idle(rb(6), 1, 7);
    idle(rb(6), 1, 7);
    idle(0, 0, 7);

    // mul r7, then lw r7: WAW stall until cnt[7]<=1, load count overrides decrement.
    step(1, 0, 0, 0, 0, 1, 7, MUL,  0,  0, 0,     0, 7);
    step(1, 0, 0, 0, 0, 1, 7, LOAD, 0,  1, rb(7), 1, 7);
    step(1, 0, 0, 0, 0, 1, 7, LOAD, 0,  1, rb(7), 1, 8);
    step(1, 0, 0, 0, 0, 1, 7, LOAD, 0,  0, rb(7), 1, 9);
    idle(rb(7), 0, 9);
    idle(0, 0, 9);

    // Flush beats stall and sets nothing; r0 never stalls or tracks.
    step(1, 0, 0, 0, 0, 1, 2, LOAD, 0,  0, 0,     0, 9);
    step(1, 2, 1, 1, 1, 1, 3, ALU,  1,  0, rb(2), 0, 9);
    step(1, 1, 1, 1, 1, 1, 8, MUL,  1,  0, 0,     0, 9);
    idle(0, 0, 9);
    step(1, 0, 0, 0, 0, 1, 2, LOAD, 0,  0, 0,     0, 9);
    step(1, 0, 0, 1, 1, 1, 0, LOAD, 0,  0, rb(2), 0, 9);
    idle(0, 0, 9);
    // MUL to r0 still occupies the multiplier.
    step(1, 0, 0, 0, 0, 1, 0, MUL,  0,  0, 0,     0, 9);
    idle(0, 1, 9);
    idle(0, 1, 9);
    idle(0, 1, 9);
    idle(0, 0, 9);

    // Mid-operation reset with cnt[2]=1 and mul_cnt=2.
    step(1, 1, 1, 1, 1, 1, 9, MUL,  0,  0, 0,     0, 9);
    step(1, 0, 0, 0, 0, 1, 2, LOAD, 0,  0, rb(9), 1, 9);
    drive(1, 2, 9, 1, 1, 1, 3, ALU, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1, 2, 9, 1, 1, 1, 3, ALU,  0,  0, 0,     0, 0);
    idle(0, 0, 0);

    // Saturation: a self-dependent mul stalls 3 of every 4 cycles.
    satBus.id_valid   = 1'b1;
    satBus.id_rs      = 5'd1;
    satBus.id_uses_rs = 1'b1;
    satBus.id_wr_en   = 1'b1;
    satBus.id_dst     = 5'd1;
    satBus.id_kind    = MUL;
    repeat (16) @(negedge clk);
    #1;
    $display("sat step: stall_cycles=%0d after 16 cycles", satBus.stall_cycles);
    cmp("sat_before", 0, 32'(satBus.stall_cycles), 32'd12);
    repeat (24) @(negedge clk);
    #1;
    $display("sat step: stall_cycles=%0d after 40 cycles", satBus.stall_cycles);
    cmp("sat_hold", 0, 32'(satBus.stall_cycles), 32'hF);
    satBus.id_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
